isram_arbiter: RTL
==================

Name: isram_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the IF1 fetch requester and the MEM-stage data requester.
- Sits between the IF1/IF2 fetch path and the MEM stage, and drives the SRAM directly.
- Picks a winner each cycle, tracks the owner of the in-flight read, and steers read data back to the right requester.
- Raises per-requester stall requests for the pipeline controller, squashes fetch responses on branch flush, and bounds fetch starvation with a streak counter.

Parameters:
- ADDR_WD, 32, SRAM address width.
- DATA_WD, 32, SRAM data width.
- STARVE_MAX, 4, consecutive cycles fetch may be denied in favour of data before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_WD  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid this cycle.
- if_rdata  out  DATA_WD  fetch data; 0 when if_rvalid=0.
- d_req  in  1  data request.
- d_we  in  DATA_WD/8  byte write enables; 0 means read.
- d_addr  in  ADDR_WD  data address.
- d_wdata  in  DATA_WD  store data.
- d_gnt  out  1  data accepted this cycle.
- d_rvalid  out  1  load data valid this cycle.
- d_rdata  out  DATA_WD  load data; 0 when d_rvalid=0.
- flush  in  1  branch redirect (br_e).
- sram_en  out  1  SRAM enable.
- sram_we  out  DATA_WD/8  SRAM byte write enables.
- sram_addr  out  ADDR_WD  SRAM address.
- sram_wdata  out  DATA_WD  SRAM write data.
- sram_rdata  in  DATA_WD  SRAM read data, valid the cycle after a read enable.
- stallreq_if  out  1  fetch wants the SRAM but was denied.
- stallreq_mem  out  1  data wants the SRAM but was denied.

Behaviour:
- Reset (async, rst_n=0): owner=IDLE, streak=0, if_rvalid=0, d_rvalid=0. All combinational outputs resolve to 0 because no request is granted.
- Arbitration (combinational, same cycle):
  - Data has priority: d_gnt = d_req & !force_if.
  - force_if = (streak == STARVE_MAX) & if_req & !flush.
  - if_gnt = if_req & !flush & (!d_req | force_if).
  - At most one grant per cycle.
- SRAM drive:
  - sram_en = if_gnt | d_gnt.
  - Address and write data come from the winner; sram_we = d_gnt ? d_we : 0.
  - When there is no grant, sram_addr, sram_wdata and sram_we are 0.
- Owner FSM (states IDLE, IF_RD, D_RD), next state evaluated every cycle:
  - IF_RD if if_gnt.
  - D_RD if d_gnt and d_we == 0.
  - Otherwise IDLE; a write produces no response.
- Responses:
  - if_rvalid = (owner == IF_RD) & !flush.
  - d_rvalid = (owner == D_RD).
  - rdata is passed from sram_rdata when valid, else 0.
  - Latency: grant in cycle N gives rvalid in N+1. Back-to-back grants give 1 result per cycle.
- Flush in cycle N:
  - No fetch grant in N.
  - A fetch response landing in N is suppressed.
  - Data grants and data responses are unaffected.
- Streak counter:
  - Increments when d_gnt & if_req & !flush, saturating at STARVE_MAX.
  - Clears to 0 when if_gnt, or when if_req=0, or when flush.
- Stall requests:
  - stallreq_if = if_req & !if_gnt & !flush.
  - stallreq_mem = d_req & !d_gnt.
- Simultaneous force_if and d_req: fetch wins, stallreq_mem=1, streak clears next cycle.
- Reset asserted mid-read: the response is dropped and no rvalid follows reset release.

Decomposition:
- Shared package (define.vh):
  - owner encoding (IDLE=2'd0, IF_RD=2'd1, D_RD=2'd2);
  - SRAM address, data and byte-enable width macros;
  - stall-request bit positions consumed by the controller.
- One sub-module, isram_arb_pick:
  - holds the streak counter;
  - produces if_gnt/d_gnt/force_if from the requests and flush.
- Owner FSM and data steering stay in the top level.

Test Plan:
- Fetch only, if_addr=0x1000 for 3 cycles, sram_rdata echoes 0xA0..0xA2 -> if_gnt=1 each cycle; if_rvalid=1 cycles 2–4 with if_rdata 0xA0,0xA1,0xA2; stallreq_if=0 throughout.
- Fetch and data load both requesting, d_addr=0x2000, sram_rdata=0xDEADBEEF -> d_gnt=1 and if_gnt=0; stallreq_if=1; next cycle d_rvalid=1, d_rdata=0xDEADBEEF, if_rvalid=0, if_rdata=0.
- Continuous d_req and if_req, STARVE_MAX=4 -> data granted 4 cycles, fetch granted on cycle 5 with stallreq_mem=1, then data granted again; pattern repeats every 5 cycles.
- Fetch grant in cycle N, flush=1 in N+1 -> if_rvalid=0 and if_rdata=0 in N+1; if_gnt=0 in N+1; streak=0 in N+2.
- Data store, d_we=4'b0011, d_wdata=0x12345678 -> sram_en=1, sram_we=4'b0011, sram_wdata=0x12345678; d_rvalid=0 next cycle; owner returns to IDLE.
- rst_n pulled low the cycle after a data load grant -> d_rvalid=0 immediately and after release; streak=0; first grant after release behaves like cold start.

Source files
------------

// File: rtl/isram_arbiter_pkg.sv
// isram_arbiter_pkg
//   Shared types and constants for the instruction/data SRAM arbiter.
//   - owner_e       : owner of the read currently in flight on the SRAM
//   - *_DFLT        : default SRAM address/data/byte-enable widths
//   - STALL_*_BIT   : bit positions of the stall requests in the vector
//                     handed to the pipeline controller
//   - CREDIT_WD     : width of the fetch starvation credit timer
package isram_arbiter_pkg;

  localparam int ADDR_WD_DFLT = 32;
  localparam int DATA_WD_DFLT = 32;
  localparam int BE_WD_DFLT   = DATA_WD_DFLT / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    D_RD  = 2'd2
  } owner_e;

  localparam int STALL_IF_BIT  = 0;
  localparam int STALL_MEM_BIT = 1;
  localparam int STALL_WD      = 2;

  // Holds STARVE_MAX values up to 15.
  localparam int CREDIT_WD = 4;

endpackage

// File: rtl/isram_arb_pick.sv
// isram_arb_pick
//   Winner selection between fetch and data requesters for the shared SRAM.
//   Data normally wins; fetch is forced through once it has been denied
//   STARVE_MAX consecutive cycles in favour of data.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   if_req, d_req      : requests from fetch and data
//   flush              : branch redirect, kills fetch this cycle
//   if_gnt, d_gnt      : one-hot-or-zero grants
//   force_if           : fetch wins this cycle because of starvation
module isram_arb_pick
  import isram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic d_req,
  input  logic flush,
  output logic if_gnt,
  output logic d_gnt,
  output logic force_if
);

  localparam logic [CREDIT_WD-1:0] CREDIT_INIT = CREDIT_WD'(STARVE_MAX);

  // Down-counting credit: the number of further data wins fetch will
  // tolerate. Reaching zero is the same as the streak hitting STARVE_MAX.
  logic [CREDIT_WD-1:0] credit;

  assign force_if = (credit == '0) & if_req & ~flush;
  assign d_gnt    = d_req & ~force_if;
  assign if_gnt   = if_req & ~flush & (~d_req | force_if);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= CREDIT_INIT;
    end else if (if_gnt || !if_req || flush) begin
      credit <= CREDIT_INIT;
    end else if (d_gnt && (credit != '0)) begin
      credit <= credit - 1'b1;
    end
  end

endmodule

// File: rtl/isram_arbiter.sv
// isram_arbiter
//   Shares one single-port synchronous SRAM (1-cycle read latency) between
//   the IF1 fetch requester and the MEM-stage data requester. Grants are
//   combinational; the owner of the in-flight read is registered and used
//   to steer sram_rdata back to the right requester on the next cycle.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   if_req/if_addr/if_gnt            : fetch request channel
//   if_rvalid/if_rdata               : fetch response (rdata 0 when invalid)
//   d_req/d_we/d_addr/d_wdata/d_gnt  : data request channel (d_we==0 is a load)
//   d_rvalid/d_rdata                 : load response (rdata 0 when invalid)
//   flush                            : branch redirect
//   sram_*                           : SRAM drive and read data
//   stallreq_if, stallreq_mem        : denied-request stalls to the controller
//
// Owner FSM
//   state | meaning
//   IDLE  | no read in flight (nothing granted, or a write)
//   IF_RD | fetch read in flight, data returns this cycle
//   D_RD  | data load in flight, data returns this cycle
module isram_arbiter
  import isram_arbiter_pkg::*;
#(
  parameter int          ADDR_WD    = ADDR_WD_DFLT,
  parameter int          DATA_WD    = DATA_WD_DFLT,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDR_WD-1:0]   if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DATA_WD-1:0]   if_rdata,
  input  logic                 d_req,
  input  logic [DATA_WD/8-1:0] d_we,
  input  logic [ADDR_WD-1:0]   d_addr,
  input  logic [DATA_WD-1:0]   d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [DATA_WD-1:0]   d_rdata,
  input  logic                 flush,
  output logic                 sram_en,
  output logic [DATA_WD/8-1:0] sram_we,
  output logic [ADDR_WD-1:0]   sram_addr,
  output logic [DATA_WD-1:0]   sram_wdata,
  input  logic [DATA_WD-1:0]   sram_rdata,
  output logic                 stallreq_if,
  output logic                 stallreq_mem
);

  localparam int BE_WD = DATA_WD / 8;

  logic                force_if;
  owner_e              owner;
  owner_e              owner_nxt;
  logic [STALL_WD-1:0] stall_vec;

  isram_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .d_req    (d_req),
    .flush    (flush),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt),
    .force_if (force_if)
  );

  // Winner drives the SRAM; idle bus is all zeros.
  always_comb begin
    sram_en    = if_gnt | d_gnt;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (d_gnt) begin
      sram_we    = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (if_gnt) begin
      sram_addr  = if_addr;
    end
  end

  // A write returns nothing, so it leaves the owner IDLE.
  always_comb begin
    owner_nxt = IDLE;
    if (if_gnt) begin
      owner_nxt = IF_RD;
    end else if (d_gnt && (d_we == BE_WD'(0))) begin
      owner_nxt = D_RD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= IDLE;
    end else begin
      owner <= owner_nxt;
    end
  end

  // A flush squashes a fetch response landing in the same cycle; loads are
  // never squashed.
  assign if_rvalid = (owner == IF_RD) & ~flush;
  assign d_rvalid  = (owner == D_RD);
  assign if_rdata  = if_rvalid ? sram_rdata : '0;
  assign d_rdata   = d_rvalid  ? sram_rdata : '0;

  assign stall_vec[STALL_IF_BIT]  = if_req & ~if_gnt & ~flush;
  assign stall_vec[STALL_MEM_BIT] = d_req & ~d_gnt;
  assign stallreq_if  = stall_vec[STALL_IF_BIT];
  assign stallreq_mem = stall_vec[STALL_MEM_BIT];

endmodule
